seg_scan_mux: RTL and testbench



---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_refresh_prescaler.sv | 27 ++
 rtl/seg_scan_mux.sv | 86 ++++++++
 tb/tb_seg_scan_mux.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Constants and types shared by the scan stage and the downstream seven-segment driver.
package seg_pkg;

    localparam int unsigned DIGIT_W    = 2;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [DIGIT_W-1:0] digit_idx_t;
    typedef logic [BCD_W-1:0]   bcd_t;

    localparam bcd_t BCD_BLANK = 4'hF;

    function automatic logic bcd_has_invalid(input logic [NUM_DIGITS*BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (v[i*BCD_W +: BCD_W] > bcd_t'(9)) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/seg_refresh_prescaler.sv
// Free-running 0..REFRESH_DIV-1 counter; o_tick marks the last count of each digit slot.
module seg_refresh_prescaler #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_count;

    assign o_tick = (r_count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit BCD scan stage: stages loads, commits them at frame wrap, and presents
// the active digit index with its (optionally leading-zero-blanked) nibble.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*BCD_W-1:0] value_i,
    input  logic                        load_i,
    output logic                        pending_o,
    output logic [DIGIT_W-1:0]          digit_sel_o,
    output logic [BCD_W-1:0]            bcd_o,
    output logic                        frame_o,
    output logic                        invalid_o
);

    logic                        w_tick;
    logic                        w_wrap;
    logic                        w_commit;
    logic [NUM_DIGITS*BCD_W-1:0] r_staging;
    logic [NUM_DIGITS*BCD_W-1:0] r_shadow;
    logic                        r_pending;
    digit_idx_t                  r_digit;
    logic                        r_frame;
    logic                        r_invalid;
    bcd_t                        w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]       w_lead_zero;

    seg_refresh_prescaler #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .o_tick(w_tick)
    );

    assign w_wrap   = w_tick && (r_digit == digit_idx_t'(NUM_DIGITS - 1));
    assign w_commit = w_wrap && r_pending;

    // A load coinciding with a commit: shadow takes the old staging, the new value stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit   <= '0;
            r_frame   <= 1'b0;
            r_staging <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_frame <= w_wrap;
            if (w_tick) r_digit <= r_digit + 1'b1;
            if (load_i) r_staging <= value_i;
            if (load_i) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            if (w_commit) begin
                r_shadow  <= r_staging;
                r_invalid <= bcd_has_invalid(r_staging);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_nib[i] = r_shadow[i*BCD_W +: BCD_W];
        end
        w_lead_zero = '0;
        w_lead_zero[NUM_DIGITS-1] = (w_nib[NUM_DIGITS-1] == '0);
        for (int unsigned k = NUM_DIGITS - 1; k > 0; k--) begin
            w_lead_zero[k-1] = w_lead_zero[k] && (w_nib[k-1] == '0);
        end
        bcd_o = w_nib[r_digit];
        if (LZ_BLANK && (r_digit != '0) && w_lead_zero[r_digit]) bcd_o = BCD_BLANK;
    end

    assign digit_sel_o = r_digit;
    assign pending_o   = r_pending;
    assign frame_o     = r_frame;
    assign invalid_o   = r_invalid;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: two instances (blanking on/off) share one stimulus stream.
module tb_seg_scan_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_i;
    logic        load_i;

    logic        a_pending, a_frame, a_invalid;
    logic [1:0]  a_dig;
    logic [3:0]  a_bcd;
    logic        b_pending, b_frame, b_invalid;
    logic [1:0]  b_dig;
    logic [3:0]  b_bcd;

    int n_chk = 0;
    int n_bad = 0;

    seg_scan_mux #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
        .pending_o(a_pending), .digit_sel_o(a_dig), .bcd_o(a_bcd),
        .frame_o(a_frame), .invalid_o(a_invalid)
    );

    seg_scan_mux #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
        .pending_o(b_pending), .digit_sel_o(b_dig), .bcd_o(b_bcd),
        .frame_o(b_frame), .invalid_o(b_invalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        value_i = v;
        load_i  = 1'b1;
        step();
        load_i  = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        step();
        while (a_frame !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        if (a_frame !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_frame got=timeout exp=frame_o at %0t", $time);
        end
    endtask

    // Starts at the first cycle of digit 0; walks one full frame, ends at the next digit 0.
    task automatic check_frame(input logic [15:0] ea, input logic [15:0] eb);
        for (int d = 0; d < 4; d++) begin
            chk("dig_a", 16'(a_dig), 16'(d));
            chk("dig_b", 16'(b_dig), 16'(d));
            chk("bcd_a", 16'(a_bcd), 16'(ea[d*4 +: 4]));
            chk("bcd_b", 16'(b_bcd), 16'(eb[d*4 +: 4]));
            step();
            if (d == 0) begin
                chk("frame_width", 16'(a_frame), 16'd0);
                chk("frame_width_b", 16'(b_frame), 16'd0);
            end
            chk("dig_mid", 16'(a_dig), 16'(d));
            repeat (3) step();
        end
        chk("frame_pulse", 16'(a_frame), 16'd1);
        chk("dig_wrap", 16'(a_dig), 16'd0);
    endtask

    initial begin
        rst_n   = 1'b1;
        load_i  = 1'b0;
        value_i = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dig", 16'(a_dig), 16'd0);
        chk("rst_bcd", 16'(a_bcd), 16'd0);
        chk("rst_pending", 16'(a_pending), 16'd0);
        chk("rst_frame", 16'(a_frame), 16'd0);
        chk("rst_invalid", 16'(a_invalid), 16'd0);
        repeat (2) step();
        rst_n = 1'b1;

        // idle scan after reset: blanked leading zeros on dut_a only
        check_frame(16'hFFF0, 16'h0000);

        // mid-frame load waits for the wrap
        repeat (5) step();
        load(16'h1234);
        chk("pend_after_load", 16'(a_pending), 16'd1);
        chk("pend_after_load_b", 16'(b_pending), 16'd1);
        chk("no_tear_a", 16'(a_bcd), 16'hF);
        chk("no_tear_b", 16'(b_bcd), 16'h0);
        wait_frame();
        chk("pend_commit", 16'(a_pending), 16'd0);
        chk("inv_1234", 16'(a_invalid), 16'd0);
        check_frame(16'h1234, 16'h1234);

        // leading-zero blanking vs plain
        load(16'h0050);
        wait_frame();
        check_frame(16'hFF50, 16'h0050);

        // last load wins
        load(16'h1111);
        repeat (2) step();
        load(16'h2222);
        wait_frame();
        chk("pend_2222", 16'(a_pending), 16'd0);
        check_frame(16'h2222, 16'h2222);

        // load in the exact digit-3 tick cycle with 1234 already staged
        load(16'h1234);
        repeat (14) step();
        load(16'h9999);
        chk("coll_frame", 16'(a_frame), 16'd1);
        chk("coll_pending", 16'(a_pending), 16'd1);
        check_frame(16'h1234, 16'h1234);
        chk("coll_pend_clear", 16'(a_pending), 16'd0);
        check_frame(16'h9999, 16'h9999);

        // invalid nibble, then asynchronous reset mid-slot with a value staged
        load(16'hA000);
        wait_frame();
        chk("inv_a000", 16'(a_invalid), 16'd1);
        chk("inv_a000_b", 16'(b_invalid), 16'd1);
        chk("pend_a000", 16'(a_pending), 16'd0);
        repeat (12) step();
        chk("dig3_a000", 16'(a_dig), 16'd3);
        chk("bcd3_a000", 16'(a_bcd), 16'hA);
        load(16'h5555);
        chk("pend_5555", 16'(a_pending), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dig", 16'(a_dig), 16'd0);
        chk("arst_bcd", 16'(a_bcd), 16'd0);
        chk("arst_pending", 16'(a_pending), 16'd0);
        chk("arst_frame", 16'(a_frame), 16'd0);
        chk("arst_invalid", 16'(a_invalid), 16'd0);
        repeat (2) step();
        rst_n = 1'b1;
        check_frame(16'hFFF0, 16'h0000);
        chk("post_rst_pending", 16'(a_pending), 16'd0);
        chk("post_rst_invalid", 16'(a_invalid), 16'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
